// File: rtl/rx_decode.sv
// rx_decode: 8b/10b receive decoder for the fixed set of code-groups emitted
// by the matching transmit encoder. Tracks running disparity, flags
// disparity errors and unsupported groups, and keeps a saturating error count.
// Code-group bit order is abcdei_fghj with 'a' in the MSB.
module rx_decode #(
    parameter int CG_WIDTH      = 10,
    parameter int OCTET_WIDTH   = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CG_WIDTH-1:0]      rx_code_group,
    input  logic                     rx_cg_valid,
    input  logic                     err_count_clr,
    output logic [OCTET_WIDTH-1:0]   rx_octet,
    output logic                     rx_is_k,
    output logic                     rx_comma,
    output logic                     rx_valid,
    output logic                     rx_invalid,
    output logic                     rx_disp_err,
    output logic                     rx_disparity,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    // Code-group constants (RD_N = encoded from RD-, RD_P = encoded from RD+)
    localparam logic [9:0] K28_5_10B_RD_N = 10'b001111_1010;
    localparam logic [9:0] K28_5_10B_RD_P = 10'b110000_0101;
    localparam logic [9:0] K23_7_10B_RD_N = 10'b111010_1000;
    localparam logic [9:0] K23_7_10B_RD_P = 10'b000101_0111;
    localparam logic [9:0] K27_7_10B_RD_N = 10'b110110_1000;
    localparam logic [9:0] K27_7_10B_RD_P = 10'b001001_0111;
    localparam logic [9:0] K29_7_10B_RD_N = 10'b101110_1000;
    localparam logic [9:0] K29_7_10B_RD_P = 10'b010001_0111;
    localparam logic [9:0] D5_6_10B_RD_N  = 10'b101001_0110;
    localparam logic [9:0] D5_6_10B_RD_P  = 10'b101001_0110;
    localparam logic [9:0] D16_2_10B_RD_N = 10'b011011_0101;
    localparam logic [9:0] D16_2_10B_RD_P = 10'b100100_0101;
    localparam logic [9:0] D0_0_10B_RD_N  = 10'b100111_0100;
    localparam logic [9:0] D0_0_10B_RD_P  = 10'b011000_1011;
    localparam logic [9:0] D1_0_10B_RD_N  = 10'b011101_0100;
    localparam logic [9:0] D1_0_10B_RD_P  = 10'b100010_1011;
    localparam logic [9:0] D2_0_10B_RD_N  = 10'b101101_0100;
    localparam logic [9:0] D2_0_10B_RD_P  = 10'b010010_1011;
    localparam logic [9:0] D2_2_10B_RD_N  = 10'b101101_0101;
    localparam logic [9:0] D2_2_10B_RD_P  = 10'b010010_0101;
    localparam logic [9:0] D21_5_10B_RD_N = 10'b101010_1010;
    localparam logic [9:0] D21_5_10B_RD_P = 10'b101010_1010;
    localparam logic [9:0] D11_3_10B_RD_N = 10'b110100_1100;
    localparam logic [9:0] D11_3_10B_RD_P = 10'b110100_0011;
    localparam logic [9:0] D23_1_10B_RD_N = 10'b111010_1001;
    localparam logic [9:0] D23_1_10B_RD_P = 10'b000101_1001;
    localparam logic [9:0] D7_4_10B_RD_N  = 10'b111000_1101;
    localparam logic [9:0] D7_4_10B_RD_P  = 10'b000111_0010;
    localparam logic [9:0] D12_5_10B_RD_N = 10'b001101_1010;
    localparam logic [9:0] D12_5_10B_RD_P = 10'b001101_1010;
    localparam logic [9:0] D28_5_10B_RD_N = 10'b001110_1010;
    localparam logic [9:0] D28_5_10B_RD_P = 10'b001110_1010;
    localparam logic [9:0] D3_6_10B_RD_N  = 10'b110001_0110;
    localparam logic [9:0] D3_6_10B_RD_P  = 10'b110001_0110;
    localparam logic [9:0] D8_6_10B_RD_N  = 10'b111001_0110;
    localparam logic [9:0] D8_6_10B_RD_P  = 10'b000110_0110;
    localparam logic [9:0] D19_2_10B_RD_N = 10'b110010_0101;
    localparam logic [9:0] D19_2_10B_RD_P = 10'b110010_0101;
    localparam logic [9:0] D24_3_10B_RD_N = 10'b110011_0011;
    localparam logic [9:0] D24_3_10B_RD_P = 10'b001100_1100;
    localparam logic [9:0] D31_1_10B_RD_N = 10'b101011_1001;
    localparam logic [9:0] D31_1_10B_RD_P = 10'b010100_1001;
    localparam logic [9:0] D10_1_10B_RD_N = 10'b010101_1001;
    localparam logic [9:0] D10_1_10B_RD_P = 10'b010101_1001;
    localparam logic [9:0] D29_3_10B_RD_N = 10'b101110_0011;
    localparam logic [9:0] D29_3_10B_RD_P = 10'b010001_1100;
    localparam logic [9:0] D4_6_10B_RD_N  = 10'b110101_0110;
    localparam logic [9:0] D4_6_10B_RD_P  = 10'b001010_0110;

    // Decode table: entry i of each array describes the same character.
    // K characters occupy entries 0..3; entry 0 is the comma K28.5.
    localparam int NUM_CODES = 24;
    localparam int COMMA_IDX = 0;

    localparam logic [9:0] CODE_RD_N [NUM_CODES] = '{
        K28_5_10B_RD_N, K23_7_10B_RD_N, K27_7_10B_RD_N, K29_7_10B_RD_N,
        D5_6_10B_RD_N,  D16_2_10B_RD_N, D0_0_10B_RD_N,  D1_0_10B_RD_N,
        D2_0_10B_RD_N,  D2_2_10B_RD_N,  D21_5_10B_RD_N, D11_3_10B_RD_N,
        D23_1_10B_RD_N, D7_4_10B_RD_N,  D12_5_10B_RD_N, D28_5_10B_RD_N,
        D3_6_10B_RD_N,  D8_6_10B_RD_N,  D19_2_10B_RD_N, D24_3_10B_RD_N,
        D31_1_10B_RD_N, D10_1_10B_RD_N, D29_3_10B_RD_N, D4_6_10B_RD_N
    };

    localparam logic [9:0] CODE_RD_P [NUM_CODES] = '{
        K28_5_10B_RD_P, K23_7_10B_RD_P, K27_7_10B_RD_P, K29_7_10B_RD_P,
        D5_6_10B_RD_P,  D16_2_10B_RD_P, D0_0_10B_RD_P,  D1_0_10B_RD_P,
        D2_0_10B_RD_P,  D2_2_10B_RD_P,  D21_5_10B_RD_P, D11_3_10B_RD_P,
        D23_1_10B_RD_P, D7_4_10B_RD_P,  D12_5_10B_RD_P, D28_5_10B_RD_P,
        D3_6_10B_RD_P,  D8_6_10B_RD_P,  D19_2_10B_RD_P, D24_3_10B_RD_P,
        D31_1_10B_RD_P, D10_1_10B_RD_P, D29_3_10B_RD_P, D4_6_10B_RD_P
    };

    // Octet = {HGF, EDCBA} i.e. Dx.y -> {y[2:0], x[4:0]}
    localparam logic [7:0] CODE_OCTET [NUM_CODES] = '{
        8'hBC, 8'hF7, 8'hFB, 8'hFD,
        8'hC5, 8'h50, 8'h00, 8'h01,
        8'h02, 8'h42, 8'hB5, 8'h6B,
        8'h37, 8'h87, 8'hAC, 8'hBC,
        8'hC3, 8'hC8, 8'h53, 8'h78,
        8'h3F, 8'h2A, 8'h7D, 8'hC4
    };

    localparam logic [NUM_CODES-1:0] CODE_IS_K = NUM_CODES'(4'hF);

    // Popcount thresholds for the running-disparity update
    localparam int                CNT_W    = $clog2(CG_WIDTH + 1);
    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CG_WIDTH / 2);

    logic [OCTET_WIDTH-1:0]   octet_reg,     octet_next;
    logic                     is_k_reg,      is_k_next;
    logic                     comma_reg,     comma_next;
    logic                     valid_reg,     valid_next;
    logic                     invalid_reg,   invalid_next;
    logic                     disp_err_reg,  disp_err_next;
    logic                     disparity_reg, disparity_next;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg,   err_cnt_next;

    logic [NUM_CODES-1:0]     hit_n;
    logic [NUM_CODES-1:0]     hit_p;
    logic [NUM_CODES-1:0]     hit_cur;
    logic [NUM_CODES-1:0]     hit_opp;
    logic [NUM_CODES-1:0]     hit_sel;
    logic                     match_cur;
    logic                     match_opp;
    logic [OCTET_WIDTH-1:0]   dec_octet;
    logic                     dec_is_k;
    logic                     dec_comma;
    logic [CNT_W-1:0]         ones_cnt;

    // One comparator per table entry for each disparity column
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CODES; gi++) begin : g_match
            assign hit_n[gi] = (rx_code_group == CG_WIDTH'(CODE_RD_N[gi]));
            assign hit_p[gi] = (rx_code_group == CG_WIDTH'(CODE_RD_P[gi]));
        end
    endgenerate

    // Prefer the current-disparity column; fall back to the opposite one.
    // Groups identical in both columns always hit the current column.
    always_comb begin
        hit_cur   = disparity_reg ? hit_p : hit_n;
        hit_opp   = disparity_reg ? hit_n : hit_p;
        match_cur = |hit_cur;
        match_opp = |hit_opp;
        hit_sel   = match_cur ? hit_cur : hit_opp;
        dec_octet = '0;
        dec_is_k  = 1'b0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (hit_sel[i]) begin
                dec_octet = dec_octet | OCTET_WIDTH'(CODE_OCTET[i]);
                dec_is_k  = dec_is_k | CODE_IS_K[i];
            end
        end
        dec_comma = hit_sel[COMMA_IDX];
    end

    // Count ones in the received group for the disparity rule
    always_comb begin
        ones_cnt = '0;
        for (int i = 0; i < CG_WIDTH; i++) begin
            ones_cnt = ones_cnt + CNT_W'(rx_code_group[i]);
        end
    end

    // Next-state: decode on valid, hold data fields otherwise, count errors
    always_comb begin
        octet_next     = octet_reg;
        is_k_next      = is_k_reg;
        comma_next     = comma_reg;
        valid_next     = 1'b0;
        invalid_next   = 1'b0;
        disp_err_next  = 1'b0;
        disparity_next = disparity_reg;
        err_cnt_next   = err_cnt_reg;

        if (rx_cg_valid) begin
            valid_next = 1'b1;
            if (match_cur || match_opp) begin
                octet_next    = dec_octet;
                is_k_next     = dec_is_k;
                comma_next    = dec_comma;
                disp_err_next = !match_cur;
            end else begin
                octet_next   = '0;
                is_k_next    = 1'b0;
                comma_next   = 1'b0;
                invalid_next = 1'b1;
            end

            // Disparity follows the raw group weight, even for bad groups
            if (ones_cnt > HALF_CNT) begin
                disparity_next = 1'b1;
            end else if (ones_cnt < HALF_CNT) begin
                disparity_next = 1'b0;
            end

            if (!match_cur && !(&err_cnt_reg)) begin
                err_cnt_next = err_cnt_reg + 1'b1;
            end
        end

        // Clear wins over a same-cycle increment
        if (err_count_clr) begin
            err_cnt_next = '0;
        end
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            octet_reg     <= '0;
            is_k_reg      <= 1'b0;
            comma_reg     <= 1'b0;
            valid_reg     <= 1'b0;
            invalid_reg   <= 1'b0;
            disp_err_reg  <= 1'b0;
            disparity_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            octet_reg     <= octet_next;
            is_k_reg      <= is_k_next;
            comma_reg     <= comma_next;
            valid_reg     <= valid_next;
            invalid_reg   <= invalid_next;
            disp_err_reg  <= disp_err_next;
            disparity_reg <= disparity_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign rx_octet     = octet_reg;
    assign rx_is_k      = is_k_reg;
    assign rx_comma     = comma_reg;
    assign rx_valid     = valid_reg;
    assign rx_invalid   = invalid_reg;
    assign rx_disp_err  = disp_err_reg;
    assign rx_disparity = disparity_reg;
    assign err_count    = err_cnt_reg;

endmodule

// File: tb/tb_rx_decode.sv
// tb_rx_decode: directed vector table, saturation sequence and randomized
// stimulus for rx_decode. The reference model builds its code table by
// running a textbook 8b/10b encoder over the supported (x, y, K) characters.
module tb_rx_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rx_code_group;
    logic        rx_cg_valid;
    logic        err_count_clr;
    logic [7:0]  rx_octet;
    logic        rx_is_k;
    logic        rx_comma;
    logic        rx_valid;
    logic        rx_invalid;
    logic        rx_disp_err;
    logic        rx_disparity;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    rx_decode #(
        .CG_WIDTH      (10),
        .OCTET_WIDTH   (8),
        .ERR_CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_code_group (rx_code_group),
        .rx_cg_valid   (rx_cg_valid),
        .err_count_clr (err_count_clr),
        .rx_octet      (rx_octet),
        .rx_is_k       (rx_is_k),
        .rx_comma      (rx_comma),
        .rx_valid      (rx_valid),
        .rx_invalid    (rx_invalid),
        .rx_disp_err   (rx_disp_err),
        .rx_disparity  (rx_disparity),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [5:0] six_tbl  [32];
    logic [3:0] four_tbl [8];
    int         ent_x    [24];
    int         ent_y    [24];
    bit         ent_k    [24];

    logic [7:0]  m_octet;
    logic        m_k, m_comma, m_valid, m_inv, m_derr, m_rd;
    int          m_err;

    // Standard 8b/10b encoding of Dx.y / Kx.y starting from disparity rd
    function automatic logic [9:0] enc(input int x, input int y, input bit k, input bit rd);
        logic [5:0] s6;
        logic [3:0] s4;
        bit         rd1;
        s6 = (k && x == 28) ? 6'b001111 : six_tbl[x];
        if (rd && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
        rd1 = ($countones(s6) != 3) ? !rd : rd;
        if (k) begin
            s4 = (y == 7) ? 4'b0111 : 4'b0101;
            if (rd1) s4 = ~s4;
        end else begin
            s4 = four_tbl[y];
            if (rd1 && ($countones(s4) != 2 || y == 3 || y == 7)) s4 = ~s4;
        end
        return {s6, s4};
    endfunction

    task automatic model_step(input bit r, input bit v, input bit c, input logic [9:0] g);
        int  cur_i, opp_i, ones;
        bit  bad;
        if (r) begin
            m_octet = 0; m_k = 0; m_comma = 0; m_valid = 0;
            m_inv = 0; m_derr = 0; m_rd = 0; m_err = 0;
            return;
        end
        bad = 0;
        if (v) begin
            cur_i = -1; opp_i = -1;
            for (int i = 0; i < 24; i++) begin
                if (cur_i < 0 && enc(ent_x[i], ent_y[i], ent_k[i], m_rd) == g) cur_i = i;
                if (opp_i < 0 && enc(ent_x[i], ent_y[i], ent_k[i], !m_rd) == g) opp_i = i;
            end
            if (cur_i < 0) cur_i = opp_i;
            m_valid = 1;
            m_derr  = (cur_i >= 0) && (cur_i == opp_i) &&
                      (enc(ent_x[cur_i], ent_y[cur_i], ent_k[cur_i], m_rd) != g);
            m_inv   = (cur_i < 0);
            if (cur_i >= 0) begin
                m_octet = 8'((ent_y[cur_i] << 5) + ent_x[cur_i]);
                m_k     = ent_k[cur_i];
                m_comma = ent_k[cur_i] && ent_x[cur_i] == 28 && ent_y[cur_i] == 5;
            end else begin
                m_octet = 0; m_k = 0; m_comma = 0;
            end
            ones = $countones(g);
            if (ones >= 6) m_rd = 1;
            else if (ones <= 4) m_rd = 0;
            bad = m_inv || m_derr;
        end else begin
            m_valid = 0; m_inv = 0; m_derr = 0;
        end
        if (c) m_err = 0;
        else if (bad && m_err < 65535) m_err = m_err + 1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".octet"},     32'(rx_octet),     32'(m_octet));
        check({tag, ".is_k"},      32'(rx_is_k),      32'(m_k));
        check({tag, ".comma"},     32'(rx_comma),     32'(m_comma));
        check({tag, ".valid"},     32'(rx_valid),     32'(m_valid));
        check({tag, ".invalid"},   32'(rx_invalid),   32'(m_inv));
        check({tag, ".disp_err"},  32'(rx_disp_err),  32'(m_derr));
        check({tag, ".disparity"}, 32'(rx_disparity), 32'(m_rd));
        check({tag, ".err_count"}, 32'(err_count),    32'(m_err));
    endtask

    // Drive one cycle of inputs, clock it, sample #1 after the edge
    task automatic cycle(input bit r, input bit v, input bit c, input logic [9:0] g);
        reset = r; rx_cg_valid = v; err_count_clr = c; rx_code_group = g;
        @(posedge clk);
        #1;
        model_step(r, v, c, g);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst, vld, clr;
        logic [9:0] cg;
        logic [7:0] octet;
        bit         k, comma, valid, inv, derr, rd;
        logic [15:0] err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input bit rst, vld, clr, input logic [9:0] cg,
                                 input logic [7:0] octet, input bit k, comma, valid,
                                 inv, derr, rd, input logic [15:0] err);
        vec_t t;
        t.rst = rst; t.vld = vld; t.clr = clr; t.cg = cg;
        t.octet = octet; t.k = k; t.comma = comma; t.valid = valid;
        t.inv = inv; t.derr = derr; t.rd = rd; t.err = err;
        return t;
    endfunction

    initial begin
        six_tbl = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                    6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                    6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                    6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                    6'b011110, 6'b101011};
        four_tbl = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        ent_x = '{28, 23, 27, 29, 5, 16, 0, 1, 2, 2, 21, 11, 23, 7, 12, 28, 3, 8, 19, 24, 31, 10, 29, 4};
        ent_y = '{ 5,  7,  7,  7, 6,  2, 0, 0, 0, 2,  5,  3,  1, 4,  5,  5, 6, 6,  2,  3,  1,  1,  3, 6};
        ent_k = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        //                 rst vld clr cg               octet  k  cm vl in de rd err
        vecs.push_back(mkv(1, 1, 0, 10'b0011111010, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0)); // reset wins
        vecs.push_back(mkv(0, 1, 0, 10'b0011111010, 8'hBC, 1, 1, 1, 0, 0, 1, 16'd0)); // K28.5 RD-
        vecs.push_back(mkv(0, 1, 0, 10'b1001000101, 8'h50, 0, 0, 1, 0, 0, 0, 16'd0)); // D16.2 RD+
        vecs.push_back(mkv(0, 1, 0, 10'b1010010110, 8'hC5, 0, 0, 1, 0, 0, 0, 16'd0)); // D5.6 neutral
        vecs.push_back(mkv(0, 1, 0, 10'b1100000101, 8'hBC, 1, 1, 1, 0, 1, 0, 16'd1)); // K28.5 wrong RD
        vecs.push_back(mkv(0, 1, 0, 10'b0000000000, 8'h00, 0, 0, 1, 1, 0, 0, 16'd2)); // invalid
        vecs.push_back(mkv(0, 1, 1, 10'b0000000000, 8'h00, 0, 0, 1, 1, 0, 0, 16'd0)); // clear wins
        vecs.push_back(mkv(0, 1, 0, 10'b1010101010, 8'hB5, 0, 0, 1, 0, 0, 0, 16'd0)); // D21.5
        vecs.push_back(mkv(0, 0, 0, 10'b0000000000, 8'hB5, 0, 0, 0, 0, 0, 0, 16'd0)); // hold
        vecs.push_back(mkv(0, 1, 0, 10'b0011111010, 8'hBC, 1, 1, 1, 0, 0, 1, 16'd0)); // K28.5 RD-
        vecs.push_back(mkv(0, 0, 0, 10'b0000000000, 8'hBC, 1, 1, 0, 0, 0, 1, 16'd0)); // hold K
        vecs.push_back(mkv(0, 1, 0, 10'b1101000011, 8'h6B, 0, 0, 1, 0, 0, 1, 16'd0)); // D11.3 RD+
        vecs.push_back(mkv(1, 1, 0, 10'b0000000000, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0)); // reset at RD+
        vecs.push_back(mkv(0, 1, 0, 10'b0011111010, 8'hBC, 1, 1, 1, 0, 0, 1, 16'd0)); // decoded vs RD-
        vecs.push_back(mkv(0, 1, 0, 10'b0110001011, 8'h00, 0, 0, 1, 0, 0, 1, 16'd0)); // D0.0 RD+
        vecs.push_back(mkv(0, 1, 0, 10'b0001010111, 8'hF7, 1, 0, 1, 0, 0, 1, 16'd0)); // K23.7 RD+
        vecs.push_back(mkv(0, 1, 0, 10'b0110110101, 8'h50, 0, 0, 1, 0, 1, 1, 16'd1)); // D16.2 wrong RD
        vecs.push_back(mkv(0, 1, 0, 10'b0011101010, 8'hBC, 0, 0, 1, 0, 0, 1, 16'd1)); // D28.5 not comma
        vecs.push_back(mkv(0, 1, 1, 10'b1010010110, 8'hC5, 0, 0, 1, 0, 0, 1, 16'd0)); // D5.6 at RD+, clr

        reset = 1'b1; rx_cg_valid = 1'b0; err_count_clr = 1'b0; rx_code_group = '0;
        cycle(1, 0, 0, 10'd0);
        check("reset.valid", 32'(rx_valid), 32'd0);
        check("reset.err_count", 32'(err_count), 32'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].vld, vecs[i].clr, vecs[i].cg);
            $display("vec %0d rst=%0b vld=%0b clr=%0b cg=%b -> oct=%h k=%0b cm=%0b v=%0b inv=%0b de=%0b rd=%0b err=%0d",
                     i, vecs[i].rst, vecs[i].vld, vecs[i].clr, vecs[i].cg, rx_octet, rx_is_k,
                     rx_comma, rx_valid, rx_invalid, rx_disp_err, rx_disparity, err_count);
            check($sformatf("vec%0d.octet", i),     32'(rx_octet),     32'(vecs[i].octet));
            check($sformatf("vec%0d.is_k", i),      32'(rx_is_k),      32'(vecs[i].k));
            check($sformatf("vec%0d.comma", i),     32'(rx_comma),     32'(vecs[i].comma));
            check($sformatf("vec%0d.valid", i),     32'(rx_valid),     32'(vecs[i].valid));
            check($sformatf("vec%0d.invalid", i),   32'(rx_invalid),   32'(vecs[i].inv));
            check($sformatf("vec%0d.disp_err", i),  32'(rx_disp_err),  32'(vecs[i].derr));
            check($sformatf("vec%0d.disparity", i), 32'(rx_disparity), 32'(vecs[i].rd));
            check($sformatf("vec%0d.err_count", i), 32'(err_count),    32'(vecs[i].err));
        end

        // ---------------- saturation sequence ----------------
        for (int i = 0; i < 65535; i++) cycle(0, 1, 0, 10'd0);
        $display("sat burst 65535 invalid groups -> err=%h", err_count);
        check("sat.reach_max", 32'(err_count), 32'hFFFF);
        check_model("sat.model");
        cycle(0, 1, 0, 10'd0);
        $display("sat extra error -> err=%h inv=%0b", err_count, rx_invalid);
        check("sat.hold_max", 32'(err_count), 32'hFFFF);
        check("sat.invalid", 32'(rx_invalid), 32'd1);
        cycle(0, 1, 0, 10'b1010101010);
        $display("sat D21.5 -> oct=%h err=%h", rx_octet, err_count);
        check("sat.good_octet", 32'(rx_octet), 32'hB5);
        check("sat.good_err", 32'(err_count), 32'hFFFF);
        cycle(0, 0, 0, 10'b0000000000);
        $display("idle -> v=%0b oct=%h err=%h", rx_valid, rx_octet, err_count);
        check("idle.valid", 32'(rx_valid), 32'd0);
        check("idle.octet_held", 32'(rx_octet), 32'hB5);
        check("idle.err_held", 32'(err_count), 32'hFFFF);
        cycle(0, 0, 1, 10'd0);
        $display("clear -> err=%h", err_count);
        check("clear.err", 32'(err_count), 32'd0);

        // ---------------- randomized stimulus ----------------
        for (int n = 0; n < 2000; n++) begin
            bit         r, v, c;
            logic [9:0] g;
            int         idx;
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) < 6) begin
                idx = $urandom_range(0, 23);
                g = enc(ent_x[idx], ent_y[idx], ent_k[idx], ($urandom_range(0, 3) == 0) ? !m_rd : m_rd);
            end else begin
                g = 10'($urandom);
            end
            cycle(r, v, c, g);
            $display("rnd %0d rst=%0b vld=%0b clr=%0b cg=%b -> oct=%h k=%0b cm=%0b v=%0b inv=%0b de=%0b rd=%0b err=%0d",
                     n, r, v, c, g, rx_octet, rx_is_k, rx_comma, rx_valid, rx_invalid,
                     rx_disp_err, rx_disparity, err_count);
            check_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_decode.md
RX_DECODE -- requirements
Module: rx_decode

Interface
REQ-001 SHALL have parameter CG_WIDTH, default 10, code-group width.
REQ-002 SHALL have parameter OCTET_WIDTH, default 8, decoded octet width.
REQ-003 SHALL have parameter ERR_CNT_WIDTH, default 16, error counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_code_group  input  CG_WIDTH  received 10-bit code-group, same bit order as the constants file.
REQ-007 SHALL have port rx_cg_valid  input  1  rx_code_group is valid this cycle.
REQ-008 SHALL have port err_count_clr  input  1  clear error counter.
REQ-009 SHALL have port rx_octet  output  OCTET_WIDTH  decoded octet.
REQ-010 SHALL have port rx_is_k  output  1  decoded group is a K character.
REQ-011 SHALL have port rx_comma  output  1  decoded group is K28.5.
REQ-012 SHALL have port rx_valid  output  1  outputs updated from a valid input.
REQ-013 SHALL have port rx_invalid  output  1  group not in the supported code table.
REQ-014 SHALL have port rx_disp_err  output  1  group valid only for the opposite running disparity.
REQ-015 SHALL have port rx_disparity  output  1  current running disparity, 0 = RD-, 1 = RD+.
REQ-016 SHALL have port err_count  output  ERR_CNT_WIDTH  saturating count of errored groups.

Function
REQ-017 SHALL decode exactly the groups the transmit encoder produces: K28.5, K23.7, K27.7, K29.7 and D5.6, D16.2, D0.0, D1.0, D2.0, D2.2, D21.5, D11.3, D23.1, D7.4, D12.5, D28.5, D3.6, D8.6, D19.2, D24.3, D31.1, D10.1, D29.3, D4.6, using the RD_N/RD_P constants from code_group_constants.v.
REQ-018 SHALL register all outputs; latency 1 cycle from rx_cg_valid=1 to rx_valid=1.
REQ-019 SHALL, when rx_cg_valid=0, drive rx_valid=0 the next cycle, hold rx_octet/rx_is_k/rx_comma/rx_disparity, clear rx_invalid/rx_disp_err, and not change err_count except by clear.
REQ-020 SHALL match first against the table of the current rx_disparity; match -> rx_octet/rx_is_k from table, rx_invalid=0, rx_disp_err=0.
REQ-021 SHALL treat a group whose RD_N and RD_P encodings are identical (e.g. D5.6) as matching either disparity.
REQ-022 SHALL, on match only in the opposite-RD table, output the decoded octet/rx_is_k with rx_disp_err=1, rx_invalid=0.
REQ-023 SHALL, on no match, output rx_octet=0, rx_is_k=0, rx_comma=0, rx_invalid=1, rx_disp_err=0.
REQ-024 SHALL update running disparity for every valid input group by popcount: 6 or more ones -> RD+, 4 or fewer -> RD-, exactly 5 -> unchanged; rule applies to valid, disparity-error and invalid groups alike.
REQ-025 SHALL assert rx_comma=1 only when the decoded group is K28.5 (either table).
REQ-026 SHALL increment err_count by 1 for each valid input group with rx_invalid or rx_disp_err set; saturate at all-ones.
REQ-027 SHALL give err_count_clr priority over increment: clear and error in same cycle -> err_count=0.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set rx_octet=0, rx_is_k=0, rx_comma=0, rx_valid=0, rx_invalid=0, rx_disp_err=0, rx_disparity=0 (RD-), err_count=0, overriding all other inputs including mid-stream input.

Verification
REQ-029 SHALL verify: reset, then K28_5_10B_RD_N with valid -> next cycle rx_octet=8'hBC, rx_is_k=1, rx_comma=1, rx_valid=1, rx_disparity=1, err_count=0.
REQ-030 SHALL verify: at RD+, D16_2_10B_RD_P (100100 0101) -> rx_octet=8'h50, rx_is_k=0, rx_disparity=0; then D5_6 -> rx_octet=8'hC5, rx_disparity stays 0.
REQ-031 SHALL verify: at RD-, K28_5_10B_RD_P (110000 0101) -> rx_octet=8'hBC, rx_disp_err=1, err_count=1, rx_disparity=0.
REQ-032 SHALL verify: 10'b0000000000 with valid -> rx_invalid=1, rx_octet=0, err_count increments; same stimulus with err_count_clr=1 -> err_count=0.
REQ-033 SHALL verify: err_count=16'hFFFF plus error -> stays 16'hFFFF; rx_cg_valid=0 -> rx_valid=0, octet held.
REQ-034 SHALL verify: reset asserted mid-stream at RD+ -> next cycle all outputs 0, rx_disparity=0; first group after reset decoded against RD-.
